// File: rtl/tsi_input_conditioner.sv
// Purpose : synchronise and debounce CH asynchronous pad inputs into clk; emit clean levels + change pulses.
// Latency : SYNC_STAGES + DB_COUNT edges from the first edge that samples a held raw_in change to clean_out.
// Backpressure: none; free-running, every output is a flop updated each clk edge.
//
// Ports:
//   clk          single system clock, all state updates on the rising edge
//   reset        synchronous active-high reset; clears sync chains, counters and all outputs
//   raw_in       asynchronous pad-buffer outputs, one bit per channel
//   clean_out    debounced, synchronised level per channel
//   rise_out     one-cycle pulse when clean_out[i] goes 0->1 (TSI_EDGE_PULSE_EN builds only)
//   fall_out     one-cycle pulse when clean_out[i] goes 1->0 (TSI_EDGE_PULSE_EN builds only)
//   changed_out  one-cycle pulse in the cycle any clean_out bit shows a new value
//
// Optional feature macro: TSI_EDGE_PULSE_EN. When undefined, rise_out/fall_out are
// tied to 0 and no edge registers are built.

module tsi_input_conditioner #(
  parameter int CH          = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DB_COUNT    = 500000,
  parameter int CNT_W       = 20
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CH-1:0] raw_in,
  output logic [CH-1:0] clean_out,
  output logic [CH-1:0] rise_out,
  output logic [CH-1:0] fall_out,
  output logic          changed_out
);

  // Terminal count: the edge on which the counter sits here with a still-differing
  // input is the edge that commits the new level.
  localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(DB_COUNT - 1);

  logic [SYNC_STAGES-1:0][CH-1:0] r_sync;
  logic [CNT_W-1:0]               r_cnt [CH];
  logic [CH-1:0]                  r_clean;
  logic                           r_changed;

  logic [CH-1:0] w_sync;
  logic [CH-1:0] w_differ;
  logic [CH-1:0] w_expire;

  assign w_sync   = r_sync[SYNC_STAGES-1];
  assign w_differ = w_sync ^ r_clean;

  always_comb begin
    w_expire = '0;
    for (int i = 0; i < CH; i++) begin
      w_expire[i] = w_differ[i] && (r_cnt[i] == LP_CNT_MAX);
    end
  end

  // Plain flop chain per channel; nothing between stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= raw_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
    end
  end

  // Counter returns to 0 whenever input and clean level agree (glitch rejected)
  // or when the change commits, so it never passes LP_CNT_MAX.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (!w_differ[i] || w_expire[i]) begin
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Expiring channels flip; changed pulse lands in the same cycle the new level appears.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clean   <= '0;
      r_changed <= 1'b0;
    end else begin
      r_clean   <= r_clean ^ w_expire;
      r_changed <= |w_expire;
    end
  end

  assign clean_out   = r_clean;
  assign changed_out = r_changed;

`ifdef TSI_EDGE_PULSE_EN
  logic [CH-1:0] r_rise;
  logic [CH-1:0] r_fall;

  // The committed level equals w_sync on an expiring bit, so rise/fall are exclusive per bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      r_rise <= w_expire & w_sync;
      r_fall <= w_expire & ~w_sync;
    end
  end

  assign rise_out = r_rise;
  assign fall_out = r_fall;
`else
  assign rise_out = '0;
  assign fall_out = '0;
`endif

endmodule

// File: tb/tb_tsi_input_conditioner.sv
// Purpose : directed self-checking bench for tsi_input_conditioner (CH=4, SYNC_STAGES=2, DB_COUNT=4).
// Latency : expected clean change on the 6th edge after a held input change is first sampled.
// Backpressure: not applicable; outputs sampled 1 time unit after each rising edge.

module tb_tsi_input_conditioner;

  localparam int CH = 4;

`ifdef TSI_EDGE_PULSE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic [CH-1:0] raw_in;
  logic [CH-1:0] clean_out;
  logic [CH-1:0] rise_out;
  logic [CH-1:0] fall_out;
  logic          changed_out;

  int n_tests = 0;
  int n_fail  = 0;

  tsi_input_conditioner #(
    .CH          (CH),
    .SYNC_STAGES (2),
    .DB_COUNT    (4),
    .CNT_W       (20)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .raw_in      (raw_in),
    .clean_out   (clean_out),
    .rise_out    (rise_out),
    .fall_out    (fall_out),
    .changed_out (changed_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observation vector: {clean_out, changed_out, rise_out, fall_out}
  logic [12:0] obs;
  assign obs = {clean_out, changed_out, rise_out, fall_out};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [CH-1:0] v);
    reset  = 1'b1;
    raw_in = v;
    tick();
    reset  = 1'b0;
  endtask

  task automatic test_reset();
    logic [12:0] exp;
    int pulses;
    reset  = 1'b1;
    raw_in = 4'hF;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (obs !== 13'h0) begin
        n_fail++;
        $display("FAIL reset_hold cyc=%0d got=%h want=%h", i, obs, 13'h0);
      end
    end
    reset  = 1'b0;
    pulses = 0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      exp = {(e >= 6) ? 4'hF : 4'h0, e == 6,
             (EDGE_EN && e == 6) ? 4'hF : 4'h0, 4'h0};
      if (changed_out === 1'b1) pulses++;
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL reset_release edge=%0d got=%h want=%h", e, obs, exp);
      end
    end
    n_tests++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL reset_changed_count got=%0d want=1", pulses);
    end
  endtask

  task automatic test_single_rise();
    logic [12:0] exp;
    do_reset(4'h0);
    raw_in = 4'h1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      exp = {(e >= 6) ? 4'h1 : 4'h0, e == 6,
             (EDGE_EN && e == 6) ? 4'h1 : 4'h0, 4'h0};
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL single_rise edge=%0d got=%h want=%h", e, obs, exp);
      end
    end
  endtask

  task automatic test_glitch();
    logic [12:0] exp;
    // 3-cycle high on channel 1: rejected
    for (int e = 1; e <= 10; e++) begin
      raw_in = (e <= 3) ? 4'h3 : 4'h1;
      tick();
      exp = {4'h1, 1'b0, 4'h0, 4'h0};
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL glitch3 edge=%0d got=%h want=%h", e, obs, exp);
      end
    end
    // 4-cycle high: accepted, then the return low is itself debounced
    for (int e = 1; e <= 12; e++) begin
      raw_in = (e <= 4) ? 4'h3 : 4'h1;
      tick();
      exp = {(e >= 6 && e <= 9) ? 4'h3 : 4'h1, (e == 6 || e == 10),
             (EDGE_EN && e == 6) ? 4'h2 : 4'h0,
             (EDGE_EN && e == 10) ? 4'h2 : 4'h0};
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL glitch4 edge=%0d got=%h want=%h", e, obs, exp);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [12:0] exp;
    raw_in = 4'hD;
    for (int e = 1; e <= 8; e++) begin
      tick();
      exp = {(e >= 6) ? 4'hD : 4'h1, e == 6,
             (EDGE_EN && e == 6) ? 4'hC : 4'h0, 4'h0};
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL simul_rise edge=%0d got=%h want=%h", e, obs, exp);
      end
    end
    raw_in = 4'h1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      exp = {(e >= 6) ? 4'h1 : 4'hD, e == 6, 4'h0,
             (EDGE_EN && e == 6) ? 4'hC : 4'h0};
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL simul_fall edge=%0d got=%h want=%h", e, obs, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [12:0] exp;
    do_reset(4'h0);
    raw_in = 4'h1;
    // after 4 edges channel 0 count is 2, change still pending
    for (int e = 1; e <= 4; e++) begin
      tick();
      n_tests++;
      if (obs !== 13'h0) begin
        n_fail++;
        $display("FAIL mid_pending edge=%0d got=%h want=%h", e, obs, 13'h0);
      end
    end
    reset = 1'b1;
    tick();
    n_tests++;
    if (obs !== 13'h0) begin
      n_fail++;
      $display("FAIL mid_reset got=%h want=%h", obs, 13'h0);
    end
    reset = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      exp = {(e >= 6) ? 4'h1 : 4'h0, e == 6,
             (EDGE_EN && e == 6) ? 4'h1 : 4'h0, 4'h0};
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL mid_relatch edge=%0d got=%h want=%h", e, obs, exp);
      end
    end
  endtask

  task automatic test_sustained();
    int bad_lvl = 0;
    int chg     = 0;
    int edges   = 0;
    raw_in = 4'h1;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (clean_out !== 4'h1) bad_lvl++;
      if (changed_out !== 1'b0) chg++;
      if (rise_out !== 4'h0 || fall_out !== 4'h0) edges++;
    end
    n_tests++;
    if (bad_lvl != 0) begin
      n_fail++;
      $display("FAIL sustained_level bad_cycles=%0d want=0", bad_lvl);
    end
    n_tests++;
    if (chg != 0) begin
      n_fail++;
      $display("FAIL sustained_changed pulses=%0d want=0", chg);
    end
    n_tests++;
    if (edges != 0) begin
      n_fail++;
      $display("FAIL sustained_edges pulses=%0d want=0", edges);
    end
  endtask

  initial begin
    reset  = 1'b1;
    raw_in = '0;
    test_reset();
    test_single_rise();
    test_glitch();
    test_simultaneous();
    test_reset_mid();
    test_sustained();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
